// File: rtl/route_select_ctrl_if.sv
// Route-select bus: head/route handshake with the input buffers, the
// routing_odd_even unit and the downstream credit counters.
interface route_select_ctrl_if #(
  parameter int N_PORTS   = 5,
  parameter int M_ENTRIES = 4,
  parameter int CREDIT_W  = 3
);
  logic [N_PORTS-1:0]                      i_head_valid;
  logic [N_PORTS-1:0]                      i_dest_local;
  logic [N_PORTS-1:0]                      i_tail_sent;
  logic [N_PORTS-1:0]                      o_routing_calculate;
  logic [N_PORTS-1:0]                      i_select_neighbor;
  logic [N_PORTS-1:0][M_ENTRIES-1:0][1:0]  i_avail_directions;
  logic [N_PORTS-1:0][CREDIT_W-1:0]        i_credit;
  logic [N_PORTS-1:0]                      o_route_valid;
  logic [N_PORTS-1:0][2:0]                 o_out_port;
  logic [N_PORTS-1:0]                      o_out_busy;
  logic                                    o_route_err;

  // Drives the router-side inputs (buffers, routing unit, credits).
  modport master (
    output i_head_valid, i_dest_local, i_tail_sent, i_select_neighbor,
           i_avail_directions, i_credit,
    input  o_routing_calculate, o_route_valid, o_out_port, o_out_busy, o_route_err
  );

  // The sequencer/allocator itself.
  modport slave (
    input  i_head_valid, i_dest_local, i_tail_sent, i_select_neighbor,
           i_avail_directions, i_credit,
    output o_routing_calculate, o_route_valid, o_out_port, o_out_busy, o_route_err
  );
endinterface

// File: rtl/route_select_ctrl.sv
// Per-input route sequencer and output-port allocator for one mesh router.
// Each input walks IDLE->CALC->SELECT->ACTIVE; outputs are shared through a
// per-output round-robin arbiter and held until the packet tail leaves.

// One lane: pick the eligible latched candidate with the most credit.
module route_pick #(
  parameter int N_PORTS   = 5,
  parameter int M_ENTRIES = 4,
  parameter int CREDIT_W  = 3
) (
  input  logic                             en,
  input  logic [M_ENTRIES-2:0][2:0]        cand,
  input  logic [1:0]                       cnt,
  input  logic [N_PORTS-1:0]               busy,
  input  logic [N_PORTS-1:0][CREDIT_W-1:0] credit,
  output logic                             req,
  output logic [2:0]                       port
);
  logic [CREDIT_W-1:0] best;

  // Strict '>' keeps credit ties on the lowest list index.
  always_comb begin
    req  = 1'b0;
    port = '0;
    best = '0;
    for (int k = 0; k < M_ENTRIES-1; k++) begin
      if (en && (2'(k) < cnt) && !busy[cand[k]] && (credit[cand[k]] != '0) &&
          (!req || (credit[cand[k]] > best))) begin
        req  = 1'b1;
        port = cand[k];
        best = credit[cand[k]];
      end
    end
  end
endmodule

module route_select_ctrl #(
  parameter int N_PORTS   = 5,
  parameter int M_ENTRIES = 4,
  parameter int CREDIT_W  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  route_select_ctrl_if.slave  bus
);
  localparam int NC = M_ENTRIES - 1;  // candidate slots; last entry is the count

  typedef enum logic [1:0] {IDLE, CALC, SELECT, ACTIVE} st_e;

  st_e                               st_q [N_PORTS];
  st_e                               st_d [N_PORTS];
  logic [N_PORTS-1:0][NC-1:0][2:0]   cand_q, cand_d;
  logic [N_PORTS-1:0][1:0]           cnt_q, cnt_d;
  logic [N_PORTS-1:0][2:0]           rr_q, rr_d;
  logic [N_PORTS-1:0][2:0]           port_q, port_d;
  logic [N_PORTS-1:0]                vld_q, vld_d, busy_q, busy_d;
  logic                              err_q, err_d;
  logic [N_PORTS-1:0]                calc, req, gnt;
  logic [N_PORTS-1:0][2:0]           req_port;
  logic [N_PORTS-1:0][N_PORTS-1:0]   reqm;
  logic [N_PORTS-1:0][3:0]           pick;

  // First requester at or after ptr, wrapping N_PORTS-1 -> 0; {hit, index}.
  function automatic logic [3:0] rr_pick(input logic [2:0] ptr,
                                         input logic [N_PORTS-1:0] reqs);
    logic [3:0] r;
    logic [2:0] idx;
    r   = '0;
    idx = ptr;
    for (int off = 0; off < N_PORTS; off++) begin
      if (!r[3] && reqs[idx]) r = {1'b1, idx};
      idx = (idx == 3'(N_PORTS-1)) ? 3'd0 : idx + 3'd1;
    end
    return r;
  endfunction

  for (genvar g = 0; g < N_PORTS; g++) begin : g_pick
    route_pick #(.N_PORTS(N_PORTS), .M_ENTRIES(M_ENTRIES), .CREDIT_W(CREDIT_W)) u_pick (
      .en     (st_q[g] == SELECT),
      .cand   (cand_q[g]),
      .cnt    (cnt_q[g]),
      .busy   (busy_q),
      .credit (bus.i_credit),
      .req    (req[g]),
      .port   (req_port[g])
    );
  end

  // Per-output round-robin among inputs requesting that output.
  always_comb begin
    reqm = '0;
    pick = '0;
    gnt  = '0;
    rr_d = rr_q;
    for (int p = 0; p < N_PORTS; p++) begin
      for (int i = 0; i < N_PORTS; i++)
        reqm[p][i] = req[i] && (req_port[i] == 3'(p));
      pick[p] = rr_pick(rr_q[p], reqm[p]);
      if (pick[p][3]) begin
        gnt[pick[p][2:0]] = 1'b1;
        rr_d[p] = (pick[p][2:0] == 3'(N_PORTS-1)) ? 3'd0 : pick[p][2:0] + 3'd1;
      end
    end
  end

  // Per-input sequencing, candidate latch and binding bookkeeping.
  always_comb begin
    st_d   = st_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    port_d = port_q;
    busy_d = busy_q;
    err_d  = err_q;
    calc   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      case (st_q[i])
        IDLE: if (bus.i_head_valid[i]) begin
          if (bus.i_dest_local[i]) begin
            cand_d[i] = '0;        // slot 0 = local port
            cnt_d[i]  = 2'd1;
            st_d[i]   = SELECT;
          end else begin
            st_d[i] = CALC;
          end
        end
        CALC: begin
          calc[i] = 1'b1;
          if (bus.i_select_neighbor[i]) begin
            cnt_d[i] = bus.i_avail_directions[i][NC];
            for (int k = 0; k < NC; k++)
              cand_d[i][k] = {1'b0, bus.i_avail_directions[i][k]} + 3'd1;
            if (bus.i_avail_directions[i][NC] == 2'd0) begin
              err_d   = 1'b1;
              st_d[i] = IDLE;
            end else begin
              st_d[i] = SELECT;
            end
          end
        end
        SELECT: if (gnt[i]) begin
          st_d[i]              = ACTIVE;
          vld_d[i]             = 1'b1;
          port_d[i]            = req_port[i];
          busy_d[req_port[i]]  = 1'b1;
        end
        ACTIVE: if (bus.i_tail_sent[i]) begin
          st_d[i]            = IDLE;
          vld_d[i]           = 1'b0;
          port_d[i]          = '0;
          busy_d[port_q[i]]  = 1'b0;
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  // State registers; reset drops every binding in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORTS; i++) st_q[i] <= IDLE;
      cand_q <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
      port_q <= '0;
      vld_q  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) st_q[i] <= st_d[i];
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      port_q <= port_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_routing_calculate = calc;
  assign bus.o_route_valid       = vld_q;
  assign bus.o_out_port          = port_q;
  assign bus.o_out_busy          = busy_q;
  assign bus.o_route_err         = err_q;
endmodule
